mem_port_arbiter: RTL

Round-robin arbiter that shares the single-port word memory (`mem`, 2048 bytes, 16-bit big-endian words at even byte addresses) between up to N_REQ engines (LearnCosts, WinnerPolicy, RNG, host loader). Each access takes two cycles: an arbitration cycle and an access cycle. Read data is registered and returned with a per-requester valid pulse. A per-requester lock keeps ownership across read-modify-write sequences. Illegal addresses are trapped before they reach the memory.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_rr_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the word-memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_DEPTH  = 2048;
    localparam int WORD_WIDTH = 16;

    localparam logic [15:0] MAX_WORD_ADDR = 16'h07FE;

    // Region bases inside the shared word memory
    localparam logic [15:0] KNOWN_SINKS_BASE      = 16'h0008;
    localparam logic [15:0] NEIGHBOR_ID_BASE      = 16'h0048;
    localparam logic [15:0] BETTER_NEIGHBORS_BASE = 16'h0668;
    localparam logic [15:0] RNG_SEED_ADDR         = 16'h07FE;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!any && eligible[cand]) begin
                any    = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-cycle round-robin arbiter with ownership lock and illegal-address
// trapping in front of the single-port word memory.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                clock,
    input  logic                nrst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    wr,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [N_REQ-1:0]    err,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_wr_en,
    output logic [DATA_W-1:0]   mem_data_in,
    input  logic [DATA_W-1:0]   mem_data_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state, state_d;
    logic [IDX_W-1:0] owner, owner_d;
    logic [IDX_W-1:0] ptr, ptr_d;
    logic [IDX_W-1:0] winner;
    logic             locked, locked_d;
    logic             any;
    logic [N_REQ-1:0] owner_mask;
    logic [N_REQ-1:0] eligible;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic             legal;

    assign owner_mask = N_REQ'(1) << owner;
    assign cur_addr   = addr[int'(owner)*ADDR_W +: ADDR_W];
    assign cur_wdata  = wdata[int'(owner)*DATA_W +: DATA_W];
    assign legal      = !cur_addr[0] &&
                        (32'(cur_addr) <= 32'(MAX_WORD_ADDR));

    // While the lock is still requested only the owner may compete
    assign eligible = (locked && lock[owner]) ? (req & owner_mask) : req;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .any      (any),
        .winner   (winner)
    );

    always_comb begin
        state_d     = state;
        owner_d     = owner;
        ptr_d       = ptr;
        locked_d    = locked;
        gnt         = '0;
        mem_address = '0;
        mem_wr_en   = 1'b0;
        mem_data_in = '0;
        unique case (state)
            IDLE: begin
                if (locked && !lock[owner]) begin
                    locked_d = 1'b0;
                end
                if (any) begin
                    owner_d = winner;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_address = cur_addr;
                mem_data_in = cur_wdata;
                // nrst gating keeps a reset edge from landing a write
                mem_wr_en   = wr[owner] & legal & nrst;
                gnt         = owner_mask;
                ptr_d       = owner;
                locked_d    = lock[owner];
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state  <= IDLE;
            owner  <= '0;
            ptr    <= IDX_W'(N_REQ - 1);
            locked <= 1'b0;
            rvalid <= '0;
            err    <= '0;
            rdata  <= '0;
        end else begin
            state  <= state_d;
            owner  <= owner_d;
            ptr    <= ptr_d;
            locked <= locked_d;
            rvalid <= '0;
            err    <= '0;
            if (state == ACCESS) begin
                if (!legal) begin
                    err <= owner_mask;
                end else if (!wr[owner]) begin
                    rvalid <= owner_mask;
                    rdata  <= mem_data_out;
                end
            end
        end
    end

endmodule
